// File: rtl/arbiter_input_route_ctrl.sv
// Input-port route/request controller: picks an output port for the head flit,
// requests it from the output arbiter, and pops the packet once granted.
`ifndef IDX_E
`define IDX_E  0
`define IDX_W  1
`define IDX_N  2
`define IDX_S  3
`define IDX_U  4
`define IDX_D  5
`define IDX_IP 6
`endif

module arbiter_input_route_ctrl #(
    parameter int          ADAPTIVE  = 1,
    parameter logic [1:0]  FT_BODY   = 2'b00,
    parameter logic [1:0]  FT_TAIL   = 2'b01,
    parameter logic [1:0]  FT_HEAD   = 2'b10,
    parameter logic [1:0]  FT_SINGLE = 2'b11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] AddrDiff,
    input  logic [1:0] Flit_Type,
    input  logic       Buf_Empty,
    input  logic [6:0] Credit_Avail,
    input  logic [6:0] Grant,
    output logic [6:0] Req,
    output logic [6:0] Route_Sel,
    output logic       Buf_Rd,
    output logic       Busy,
    output logic       Err_Drop
);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t     state_q, state_d;
    logic [6:0] route_q, route_d;
    logic [6:0] req_q, req_d;
    logic       buf_rd, err_drop;

    logic [5:0] dir, dir_cr, pick_src, pick;
    logic [6:0] route_calc;
    logic       is_start, is_end;

    assign is_start = (Flit_Type == FT_HEAD) || (Flit_Type == FT_SINGLE);
    assign is_end   = (Flit_Type == FT_TAIL) || (Flit_Type == FT_SINGLE);

    // Candidates packed in priority order E,W,N,S,U,D; lowest set bit wins.
    always_comb begin
        dir = {AddrDiff[`IDX_D], AddrDiff[`IDX_U], AddrDiff[`IDX_S],
               AddrDiff[`IDX_N], AddrDiff[`IDX_W], AddrDiff[`IDX_E]};
        dir_cr = dir & {Credit_Avail[`IDX_D], Credit_Avail[`IDX_U], Credit_Avail[`IDX_S],
                        Credit_Avail[`IDX_N], Credit_Avail[`IDX_W], Credit_Avail[`IDX_E]};
        pick_src = ((ADAPTIVE != 0) && (dir_cr != '0)) ? dir_cr : dir;
        pick     = pick_src & (~pick_src + 6'd1);
        route_calc          = '0;
        route_calc[`IDX_E]  = pick[0];
        route_calc[`IDX_W]  = pick[1];
        route_calc[`IDX_N]  = pick[2];
        route_calc[`IDX_S]  = pick[3];
        route_calc[`IDX_U]  = pick[4];
        route_calc[`IDX_D]  = pick[5];
        route_calc[`IDX_IP] = (dir == '0);
    end

    always_comb begin
        state_d  = state_q;
        route_d  = route_q;
        req_d    = req_q;
        buf_rd   = 1'b0;
        err_drop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!Buf_Empty) begin
                    if (is_start) begin
                        route_d = route_calc;
                        req_d   = route_calc;
                        state_d = REQ;
                    end else begin
                        buf_rd   = 1'b1;
                        err_drop = 1'b1;
                    end
                end
            end
            REQ: begin
                if ((Grant & route_q) != '0) state_d = XFER;
            end
            XFER: begin
                buf_rd = !Buf_Empty && ((Grant & route_q) != '0) && ((Credit_Avail & route_q) != '0);
                if (buf_rd && is_end) begin
                    state_d = IDLE;
                    route_d = '0;
                    req_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                route_d = '0;
                req_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            route_q <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            req_q   <= req_d;
        end
    end

    assign Req       = req_q;
    assign Route_Sel = route_q;
    assign Busy      = (state_q != IDLE);
    assign Buf_Rd    = buf_rd & ~rst;
    assign Err_Drop  = err_drop & ~rst;

endmodule

// File: tb/tb_arbiter_input_route_ctrl.sv
// Randomized bench for arbiter_input_route_ctrl against a packet-level model
// of the input buffer, route choice and grant/credit-gated forwarding.
module tb_arbiter_input_route_ctrl;

    localparam int E = 0, W = 1, N = 2, S = 3, U = 4, D = 5, IP = 6;
    localparam logic [1:0] FT_BODY = 2'b00, FT_TAIL = 2'b01, FT_HEAD = 2'b10, FT_SINGLE = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] AddrDiff, Credit_Avail, Grant;
    logic [1:0] Flit_Type;
    logic       Buf_Empty;
    logic [6:0] Req, Route_Sel;
    logic       Buf_Rd, Busy, Err_Drop;
    logic [6:0] x_Req, x_Route_Sel;
    logic       x_Buf_Rd, x_Busy, x_Err_Drop;

    arbiter_input_route_ctrl #(.ADAPTIVE(1)) u_dut (
        .clk(clk), .rst(rst), .AddrDiff(AddrDiff), .Flit_Type(Flit_Type),
        .Buf_Empty(Buf_Empty), .Credit_Avail(Credit_Avail), .Grant(Grant),
        .Req(Req), .Route_Sel(Route_Sel), .Buf_Rd(Buf_Rd), .Busy(Busy), .Err_Drop(Err_Drop)
    );

    arbiter_input_route_ctrl #(.ADAPTIVE(0)) u_dut_xyz (
        .clk(clk), .rst(rst), .AddrDiff(AddrDiff), .Flit_Type(Flit_Type),
        .Buf_Empty(Buf_Empty), .Credit_Avail(Credit_Avail), .Grant(Grant),
        .Req(x_Req), .Route_Sel(x_Route_Sel), .Buf_Rd(x_Buf_Rd), .Busy(x_Busy), .Err_Drop(x_Err_Drop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] ft;
        logic [6:0] ad;
    } flit_t;

    flit_t       fq[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned pops     = 0;
    bit          m_busy = 0, m_granted = 0;
    logic [6:0]  m_route = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic logic [6:0] ref_route(input logic [6:0] ad, input logic [6:0] cr, input bit adaptive);
        if (ad[5:0] == 6'd0) return 7'(1 << IP);
        if (adaptive)
            for (int i = 0; i < 6; i++) if (ad[i] && cr[i]) return 7'(1 << i);
        for (int i = 0; i < 6; i++) if (ad[i]) return 7'(1 << i);
        return 7'd0;
    endfunction

    task automatic push_pkt(input int len, input logic [6:0] ad);
        if (len == 1) fq.push_back('{FT_SINGLE, ad});
        else begin
            fq.push_back('{FT_HEAD, ad});
            for (int i = 0; i < len - 2; i++) fq.push_back('{FT_BODY, 7'($urandom)});
            fq.push_back('{FT_TAIL, 7'($urandom)});
        end
    endtask

    // One clock: drive at negedge, check #1 later, then advance the model.
    task automatic step(input bit r, input bit hide, input logic [6:0] cr, input logic [6:0] gr);
        flit_t f;
        bit    have, exp_pop, exp_err, is_end;
        @(negedge clk);
        have = (fq.size() > 0) && !hide;
        f    = have ? fq[0] : flit_t'(9'($urandom));
        rst = r; Buf_Empty = !have; Flit_Type = f.ft; AddrDiff = f.ad;
        Credit_Avail = cr; Grant = gr;
        #1;
        exp_pop = 0; exp_err = 0;
        if (!r && have) begin
            if (!m_busy) begin
                if (f.ft == FT_BODY || f.ft == FT_TAIL) begin exp_pop = 1; exp_err = 1; end
            end else if (m_granted) exp_pop = |(gr & cr & m_route);
        end
        check("req", Req, m_route);
        check("route_sel", Route_Sel, m_route);
        check("busy", Busy, m_busy);
        check("buf_rd", Buf_Rd, exp_pop);
        check("err_drop", Err_Drop, exp_err);
        is_end = (f.ft == FT_TAIL) || (f.ft == FT_SINGLE);
        if (r) begin
            m_busy = 0; m_granted = 0; m_route = '0;
        end else if (!m_busy) begin
            if (have && (f.ft == FT_HEAD || f.ft == FT_SINGLE)) begin
                m_route = ref_route(f.ad, cr, 1); m_busy = 1; m_granted = 0;
            end
        end else if (!m_granted) begin
            m_granted = |(gr & m_route);
        end else if (exp_pop && is_end) begin
            m_busy = 0; m_granted = 0; m_route = '0;
        end
        if (exp_pop) begin
            fq.delete(0);
            pops++;
        end
    endtask

    task automatic do_reset();
        fq.delete();
        step(1, 1, '0, '0);
    endtask

    int unsigned p0;

    initial begin
        rst = 1; AddrDiff = '0; Flit_Type = '0; Buf_Empty = 1; Credit_Avail = '0; Grant = '0;
        repeat (2) @(posedge clk);

        // reset state, idle with empty buffer
        step(0, 1, '1, '1);

        // adaptive picks N when E lacks credit; xyz keeps E
        do_reset();
        push_pkt(1, 7'((1 << E) | (1 << N)));
        step(0, 0, 7'b1111110, '0);
        step(0, 1, '1, '0);
        check("adapt_route_n", Route_Sel, 1 << N);
        check("xyz_route_e", x_Route_Sel, 1 << E);
        check("xyz_req_e", x_Req, 1 << E);
        do_reset();
        push_pkt(1, 7'((1 << E) | (1 << N)));
        step(0, 0, '0, '0);
        step(0, 1, '0, '0);
        check("adapt_nocredit_e", Route_Sel, 1 << E);

        // 4-flit packet to IP, grant 2 cycles after Req
        do_reset();
        push_pkt(4, 7'(1 << IP));
        p0 = pops;
        step(0, 0, '1, '0);
        step(0, 0, '1, '0);
        step(0, 0, '1, '0);
        repeat (6) step(0, 0, '1, 7'(1 << IP));
        check("ip_pkt_pops", pops - p0, 4);
        check("ip_pkt_idle", Busy, 0);

        // SINGLE to D followed immediately by a HEAD
        do_reset();
        push_pkt(1, 7'(1 << D));
        push_pkt(2, 7'(1 << W));
        p0 = pops;
        repeat (10) step(0, 0, '1, '1);
        check("single_then_head_pops", pops - p0, 3);

        // credit stall mid-packet
        do_reset();
        push_pkt(6, 7'(1 << S));
        p0 = pops;
        repeat (4) step(0, 0, '1, 7'(1 << S));
        repeat (3) step(0, 0, 7'(~(1 << S)), 7'(1 << S));
        check("stall_busy", Busy, 1);
        repeat (6) step(0, 0, '1, 7'(1 << S));
        check("stall_pops", pops - p0, 6);

        // orphan body dropped; wrong-port grant ignored in REQ
        do_reset();
        fq.push_back('{FT_BODY, 7'd0});
        step(0, 0, '1, '0);
        push_pkt(2, 7'(1 << E));
        p0 = pops;
        repeat (4) step(0, 0, '1, 7'(1 << W));
        check("wrong_grant_no_pop", pops - p0, 0);
        check("wrong_grant_busy", Busy, 1);

        // reset mid-XFER after head + 2 body pops
        do_reset();
        push_pkt(6, 7'(1 << U));
        repeat (5) step(0, 0, '1, 7'(1 << U));
        step(1, 0, '1, 7'(1 << U));
        fq.delete();
        step(0, 1, '1, 7'(1 << U));
        check("rst_mid_busy", Busy, 0);
        check("rst_mid_req", Req, 0);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            logic [6:0] cr, gr;
            while (fq.size() < 4) begin
                if ($urandom_range(0, 15) == 0) fq.push_back('{2'($urandom_range(0, 1)), 7'($urandom)});
                else push_pkt(int'($urandom_range(1, 5)), 7'($urandom));
            end
            cr = 7'($urandom | $urandom);
            gr = 7'($urandom) | (($urandom_range(0, 2) != 0) ? m_route : 7'd0);
            step($urandom_range(0, 499) == 0, $urandom_range(0, 4) == 0, cr, gr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
